// File: rtl/dot_product_if.sv
// Vector-pair input and dot-product result bundle for dot_product.
// master drives the operand pair, slave (the datapath) returns the registered result.
interface dot_product_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int ACCW = 2*WIDTH + $clog2(N) + ((N == 1) ? 1 : 0);

  logic                    in_valid;
  logic signed [WIDTH-1:0] a [N];
  logic signed [WIDTH-1:0] b [N];
  logic signed [WIDTH-1:0] out;
  logic signed [ACCW-1:0]  out_full;
  logic                    out_valid;
  logic                    overflow;

  modport master (
    output in_valid, a, b,
    input  out, out_full, out_valid, overflow
  );

  modport slave (
    input  in_valid, a, b,
    output out, out_full, out_valid, overflow
  );
endinterface

// File: rtl/dot_product.sv
// Signed dot product sum(a[i]*b[i]), exact ACCW-bit sum plus WIDTH-bit wrapped copy.
// Latency 1 cycle (single output register); no backpressure, accepts a pair every cycle.
module dot_product #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic          clk,
  input  logic          rst,
  dot_product_if.slave  bus
);
  localparam int ACCW = 2*WIDTH + $clog2(N) + ((N == 1) ? 1 : 0);

  logic signed [2*WIDTH-1:0] prod [N];
  logic signed [ACCW-1:0]    sum;
  logic                      sum_ovf;

  // Operands are sign-extended to 2*WIDTH so the low half of the product is exact,
  // including the -2^(W-1) * -2^(W-1) corner.
  for (genvar i = 0; i < N; i++) begin : g_prod
    assign prod[i] = $signed({{WIDTH{bus.a[i][WIDTH-1]}}, bus.a[i]})
                   * $signed({{WIDTH{bus.b[i][WIDTH-1]}}, bus.b[i]});
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + $signed({{(ACCW-2*WIDTH){prod[i][2*WIDTH-1]}}, prod[i]});
    end
  end

  // Fits in signed WIDTH exactly when every bit from the WIDTH-1 sign position up agrees.
  assign sum_ovf = !((&sum[ACCW-1:WIDTH-1]) || (~|sum[ACCW-1:WIDTH-1]));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_full  <= '0;
      bus.out_valid <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.out       <= sum[WIDTH-1:0];
      bus.out_full  <= sum;
      bus.out_valid <= bus.in_valid;
      bus.overflow  <= sum_ovf;
    end
  end
endmodule

// File: tb/tb_dot_product.sv
// Randomized bench for dot_product against an integer-arithmetic reference model.
module tb_dot_product;
  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   va [N];
  int   vb [N];

  dot_product_if #(.WIDTH(WIDTH), .N(N)) bus ();

  dot_product #(.WIDTH(WIDTH), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus at negedge, then check the registered result after the edge.
  task automatic run(input logic v, input logic r);
    longint full;
    longint e_out;
    logic   e_ovf;
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.a[i] = 8'(va[i]);
      bus.b[i] = 8'(vb[i]);
    end
    full = 0;
    for (int i = 0; i < N; i++) full += longint'(va[i]) * longint'(vb[i]);
    e_out = longint'(byte'(full));
    e_ovf = (full > 127) || (full < -128);
    if (r) begin
      full  = 0;
      e_out = 0;
      e_ovf = 1'b0;
      v     = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out",       bus.out,       e_out);
    check("out_full",  bus.out_full,  full);
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, v});
    check("overflow",  {63'd0, bus.overflow},  {63'd0, e_ovf});
  endtask

  task automatic set_vec(input int a0, a1, a2, a3, b0, b1, b2, b3);
    va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
    vb[0] = b0; vb[1] = b1; vb[2] = b2; vb[3] = b3;
  endtask

  task automatic rand_vec();
    for (int i = 0; i < N; i++) begin
      va[i] = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
      vb[i] = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.a[i] = '0;
      bus.b[i] = '0;
    end

    set_vec(5, 6, 7, 8, 1, 2, 3, 4);
    run(1'b1, 1'b1);
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    run(1'b1, 1'b0);
    set_vec(3, 1, 1, 2, 3, 1, 2, 1);
    run(1'b1, 1'b0);
    set_vec(-1, -1, -1, -1, -1, -1, -1, -1);
    run(1'b1, 1'b0);
    set_vec(-128, -128, -128, -128, -128, -128, -128, -128);
    run(1'b1, 1'b0);
    set_vec(127, 0, 0, 0, 2, 0, 0, 0);
    run(1'b1, 1'b0);
    set_vec(-128, 127, -128, 127, 127, -128, 127, -128);
    run(1'b1, 1'b0);

    // Back-to-back stream with in_valid toggling.
    for (int k = 0; k < 3; k++) begin
      rand_vec();
      run(k != 1, 1'b0);
    end

    // Reset mid-stream with a live nonzero pair, then recovery.
    set_vec(10, 20, 30, 40, 1, 1, 1, 1);
    run(1'b1, 1'b1);
    set_vec(10, 20, 30, 40, 1, 1, 1, 1);
    run(1'b1, 1'b0);

    for (int k = 0; k < 300; k++) begin
      rand_vec();
      run(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
